// File: rtl/barcos_pkg.sv
// Shared definitions for the fleet tracker: fleet size, ship index width,
// game state encoding and the ship length rule.
package barcos_pkg;

    localparam int NUM_BARCOS = 5;
    localparam int ID_W       = 3;

    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        JUGANDO  = 2'd1,
        FIN      = 2'd2
    } estado_t;

    // Ship i is i+1 cells long, so it sinks after i+1 hits.
    function automatic logic [2:0] largo_barco(input int id);
        return 3'(id + 1);
    endfunction

endpackage

// File: rtl/contador_impactos.sv
// Per-ship hit counter. It saturates at the ship length and raises
// hundido once every cell of the ship has been hit.
module contador_impactos
    import barcos_pkg::*;
#(
    parameter logic [2:0] LARGO = largo_barco(0)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       incr,
    output logic [2:0] cuenta,
    output logic       hundido
);

    // Count accepted hits; a new game clears the count and a sunk ship stops counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cuenta <= 3'd0;
        end else if (clear) begin
            cuenta <= 3'd0;
        end else if (incr && (cuenta != LARGO)) begin
            cuenta <= cuenta + 3'd1;
        end
    end

    assign hundido = (cuenta == LARGO);

endmodule

// File: rtl/registro_barcos.sv
// Fleet hit register: tracks which of the player's ships are still afloat,
// how many remain, pulses when a ship sinks and flags the end of the game.
// All outputs are registered so the display stage sees clean values.
module registro_barcos
    import barcos_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  nuevo_juego,
    input  logic                  disparo_valido,
    input  logic [ID_W-1:0]       barco_id,
    output logic [NUM_BARCOS-1:0] barcos,
    output logic [2:0]            restantes,
    output logic                  hundido_pulso,
    output logic [ID_W-1:0]       hundido_id,
    output logic                  fin_juego
);

    estado_t               estado;
    estado_t               estado_sig;
    logic                  acepta_base;
    logic [NUM_BARCOS-1:0] golpe;
    logic [NUM_BARCOS-1:0] hunde;
    logic [NUM_BARCOS-1:0] hundido;
    logic [2:0]            cnt [NUM_BARCOS];
    logic                  hundiendo;
    logic                  ultimo;

    // A new game always wins over a simultaneous hit, and hits only count while playing.
    assign acepta_base = (estado == JUGANDO) && disparo_valido && !nuevo_juego;

    // Decode the hit per ship; ids beyond the fleet never match any ship.
    for (genvar i = 0; i < NUM_BARCOS; i++) begin : g_barco
        assign golpe[i] = acepta_base && (barco_id == ID_W'(i)) && barcos[i] && !hundido[i];
        assign hunde[i] = golpe[i] && (cnt[i] == (largo_barco(i) - 3'd1));

        contador_impactos #(
            .LARGO (largo_barco(i))
        ) u_contador (
            .clk     (clk),
            .rst     (rst),
            .clear   (nuevo_juego),
            .incr    (golpe[i]),
            .cuenta  (cnt[i]),
            .hundido (hundido[i])
        );
    end

    assign hundiendo = |hunde;
    assign ultimo    = ((barcos & ~hunde) == '0);

    // Game state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= INACTIVO;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next state: a new game restarts from any state, sinking the last ship ends it.
    always_comb begin
        estado_sig = estado;
        case (estado)
            INACTIVO: begin
                if (nuevo_juego) estado_sig = JUGANDO;
            end
            JUGANDO: begin
                if (nuevo_juego) begin
                    estado_sig = JUGANDO;
                end else if (hundiendo && ultimo) begin
                    estado_sig = FIN;
                end
            end
            FIN: begin
                if (nuevo_juego) estado_sig = JUGANDO;
            end
            default: estado_sig = INACTIVO;
        endcase
    end

    // Output registers: fleet mask, remaining count, sink pulse and id, game-over flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            barcos        <= '0;
            restantes     <= 3'd0;
            hundido_pulso <= 1'b0;
            hundido_id    <= '0;
            fin_juego     <= 1'b0;
        end else begin
            hundido_pulso <= hundiendo;
            fin_juego     <= (estado_sig == FIN);
            if (nuevo_juego) begin
                barcos    <= '1;
                restantes <= 3'(NUM_BARCOS);
            end else if (hundiendo) begin
                barcos     <= barcos & ~hunde;
                restantes  <= restantes - 3'd1;
                hundido_id <= barco_id;
            end
        end
    end

endmodule

// File: tb/tb_registro_barcos.sv
// Directed bench for the fleet hit register. Each check compares the
// packed snapshot {barcos, restantes, hundido_pulso, hundido_id, fin_juego}
// against a hand-computed value.
module tb_registro_barcos;

    logic       clk;
    logic       rst;
    logic       nuevo_juego;
    logic       disparo_valido;
    logic [2:0] barco_id;
    logic [4:0] barcos;
    logic [2:0] restantes;
    logic       hundido_pulso;
    logic [2:0] hundido_id;
    logic       fin_juego;

    logic [12:0] obs;
    logic [12:0] exp_v;
    int total;
    int bad;

    registro_barcos dut (
        .clk            (clk),
        .rst            (rst),
        .nuevo_juego    (nuevo_juego),
        .disparo_valido (disparo_valido),
        .barco_id       (barco_id),
        .barcos         (barcos),
        .restantes      (restantes),
        .hundido_pulso  (hundido_pulso),
        .hundido_id     (hundido_id),
        .fin_juego      (fin_juego)
    );

    assign obs = {barcos, restantes, hundido_pulso, hundido_id, fin_juego};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle hit strobe on the given ship.
    task automatic hit(input logic [2:0] id);
        disparo_valido = 1'b1;
        barco_id       = id;
        step();
        disparo_valido = 1'b0;
    endtask

    // One-cycle new-game request.
    task automatic new_game();
        nuevo_juego = 1'b1;
        step();
        nuevo_juego = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        exp_v = {5'b00000, 3'd0, 1'b0, 3'd0, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL reset_values: got %b want %b", obs, exp_v);
        end
        #3 rst = 1'b0;
        step();
        hit(3'd0);
        exp_v = {5'b00000, 3'd0, 1'b0, 3'd0, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL hit_while_idle: got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_single_sink();
        new_game();
        exp_v = {5'b11111, 3'd5, 1'b0, 3'd0, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL new_game_init: got %b want %b", obs, exp_v);
        end
        hit(3'd0);
        exp_v = {5'b11110, 3'd4, 1'b1, 3'd0, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL sink_ship0: got %b want %b", obs, exp_v);
        end
        step();
        exp_v = {5'b11110, 3'd4, 1'b0, 3'd0, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL pulse_one_cycle: got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            hit(3'd4);
            exp_v = {5'b11110, 3'd4, 1'b0, 3'd0, 1'b0};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("[TB] FAIL ship4_partial_%0d: got %b want %b", k, obs, exp_v);
            end
        end
        hit(3'd4);
        exp_v = {5'b01110, 3'd3, 1'b1, 3'd4, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL ship4_sink: got %b want %b", obs, exp_v);
        end
        hit(3'd4);
        exp_v = {5'b01110, 3'd3, 1'b0, 3'd4, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL ship4_after_sunk: got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_bad_ids();
        for (int k = 5; k < 8; k++) begin
            hit(3'(k));
            exp_v = {5'b01110, 3'd3, 1'b0, 3'd4, 1'b0};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("[TB] FAIL bad_id_%0d: got %b want %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_sink_all();
        hit(3'd1);
        hit(3'd1);
        exp_v = {5'b01100, 3'd2, 1'b1, 3'd1, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL sink_ship1: got %b want %b", obs, exp_v);
        end
        for (int k = 0; k < 3; k++) hit(3'd2);
        exp_v = {5'b01000, 3'd1, 1'b1, 3'd2, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL sink_ship2: got %b want %b", obs, exp_v);
        end
        for (int k = 0; k < 3; k++) hit(3'd3);
        exp_v = {5'b01000, 3'd1, 1'b0, 3'd2, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL ship3_partial: got %b want %b", obs, exp_v);
        end
        hit(3'd3);
        exp_v = {5'b00000, 3'd0, 1'b1, 3'd3, 1'b1};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL game_over: got %b want %b", obs, exp_v);
        end
        hit(3'd0);
        hit(3'd3);
        exp_v = {5'b00000, 3'd0, 1'b0, 3'd3, 1'b1};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL hits_after_fin: got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_new_game_priority();
        new_game();
        exp_v = {5'b11111, 3'd5, 1'b0, 3'd3, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL restart_from_fin: got %b want %b", obs, exp_v);
        end
        hit(3'd0);
        hit(3'd1);
        for (int k = 0; k < 4; k++) hit(3'd3);
        exp_v = {5'b10110, 3'd3, 1'b1, 3'd3, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL midgame_10110: got %b want %b", obs, exp_v);
        end
        nuevo_juego = 1'b1;
        hit(3'd1);
        exp_v = {5'b11111, 3'd5, 1'b0, 3'd3, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL new_game_over_hit: got %b want %b", obs, exp_v);
        end
        hit(3'd0);
        nuevo_juego = 1'b0;
        exp_v = {5'b11111, 3'd5, 1'b0, 3'd3, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL new_game_held: got %b want %b", obs, exp_v);
        end
        hit(3'd1);
        exp_v = {5'b11111, 3'd5, 1'b0, 3'd3, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL counter_cleared: got %b want %b", obs, exp_v);
        end
        hit(3'd1);
        exp_v = {5'b11101, 3'd4, 1'b1, 3'd1, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL ship1_fresh_sink: got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_async_reset();
        hit(3'd4);
        #3 rst = 1'b1;
        #1;
        exp_v = {5'b00000, 3'd0, 1'b0, 3'd0, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL async_reset_now: got %b want %b", obs, exp_v);
        end
        step();
        #3 rst = 1'b0;
        step();
        hit(3'd0);
        exp_v = {5'b00000, 3'd0, 1'b0, 3'd0, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL idle_after_reset: got %b want %b", obs, exp_v);
        end
        new_game();
        exp_v = {5'b11111, 3'd5, 1'b0, 3'd0, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL restart_after_reset: got %b want %b", obs, exp_v);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        nuevo_juego    = 1'b0;
        disparo_valido = 1'b0;
        barco_id       = 3'd0;
        test_reset();
        test_single_sink();
        test_back_to_back();
        test_bad_ids();
        test_sink_all();
        test_new_game_priority();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
